ifu: RTL and testbench

- Instruction fetch unit: the producer end of the 32-bit instruction interface that the decoder consumes.
- Generates sequential/redirected PCs, issues single-outstanding reads on the instruction memory port and buffers returned words in a small FIFO.
- Presents {inst, pc, fault} to the decode stage with a valid/ready handshake.
- Sits between the instruction memory/bus bridge and the decode stage; redirects come from the next-PC logic (jumps, branches, ecall/mret).

---
 rtl/ifu.sv | 170 +++++++++++++++++
 tb/tb_ifu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small {inst, pc, fault} FIFO.
// Optional IFU_PERF_EN adds fetch/stall counters.  State | meaning:
//   IDLE | no request in flight        REQ  | request presented, held until accepted
//   WAIT | accepted, awaiting response DROP | awaiting a response that will be discarded
module ifu #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault
`ifdef IFU_PERF_EN
   ,output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_valid_q, req_valid_d;
    logic        pending_drop_q, pending_drop_d;
    logic        fault_pend_q, fault_pend_d;
    logic [PW:0] wr_q, wr_d, rd_q, rd_d, count_d;

    logic [31:0] fifo_inst_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    logic        fifo_err_q  [FIFO_DEPTH];

    logic        push, pop, issue_ok, push_err;
    logic [31:0] push_inst, push_pc;
    logic [PW-1:0] rd_idx;

    assign rd_idx        = rd_q[PW-1:0];
    assign inst_valid    = (wr_q != rd_q);
    assign pop           = inst_valid && inst_ready;
    assign inst          = inst_valid ? fifo_inst_q[rd_idx] : 32'h0;
    assign inst_pc       = inst_valid ? fifo_pc_q[rd_idx]   : 32'h0;
    assign inst_fault    = inst_valid ? fifo_err_q[rd_idx]  : 1'b0;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = addr_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        addr_d         = addr_q;
        pending_drop_d = pending_drop_q;
        fault_pend_d   = fault_pend_q;
        push           = 1'b0;
        push_inst      = NOP;
        push_pc        = pc_q;
        push_err       = 1'b1;

        // A redirect flushes everything, including a fault entry not yet pushed.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            fault_pend_d = (redirect_pc[1:0] != 2'b00);
        end else if (fault_pend_q) begin
            push         = 1'b1;
            fault_pend_d = 1'b0;
        end else if (state_q == WAIT && mem_rsp_valid) begin
            push      = 1'b1;
            push_inst = mem_rsp_err ? NOP : mem_rsp_data;
            push_err  = mem_rsp_err;
            pc_d      = pc_q + 32'd4;
        end

        if (redirect_valid) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            wr_d = wr_q + (PW+1)'(push);
            rd_d = rd_q + (PW+1)'(pop);
        end
        count_d  = wr_d - rd_d;
        // A misaligned pc only changes on the next redirect, so it doubles as the idle lock.
        issue_ok = !halt && (pc_d[1:0] == 2'b00) && (count_d < (PW+1)'(FIFO_DEPTH));

        case (state_q)
            IDLE: if (issue_ok) state_d = REQ;
            REQ: begin
                if (redirect_valid) pending_drop_d = 1'b1;
                if (mem_req_ready) begin
                    state_d        = (pending_drop_q || redirect_valid) ? DROP : WAIT;
                    pending_drop_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rsp_valid)       state_d = issue_ok ? REQ : IDLE;
                else if (redirect_valid) state_d = DROP;
            end
            DROP: if (mem_rsp_valid) state_d = issue_ok ? REQ : IDLE;
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == REQ);
        if (state_d == REQ && state_q != REQ) addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            addr_q         <= 32'h0;
            req_valid_q    <= 1'b0;
            pending_drop_q <= 1'b0;
            fault_pend_q   <= 1'b0;
            wr_q           <= '0;
            rd_q           <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            addr_q         <= addr_d;
            req_valid_q    <= req_valid_d;
            pending_drop_q <= pending_drop_d;
            fault_pend_q   <= fault_pend_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_q[PW-1:0]] <= push_inst;
            fifo_pc_q[wr_q[PW-1:0]]   <= push_pc;
            fifo_err_q[wr_q[PW-1:0]]  <= push_err;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, push};
        stall_cnt_d = stall_cnt_q + {31'd0, (!inst_valid && !halt)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: a stream model predicts the {inst, pc, fault} sequence the
// decode stage should see; a memory model answers requests with addr^1 after a delay.
module tb_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        redirect_valid = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req_valid, mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        inst_valid, inst_ready = 1'b1, inst_fault;
    logic [31:0] inst, inst_pc;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_fault(inst_fault)
`ifdef IFU_PERF_EN
       ,.perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic fault;} ent_t;

    int errors = 0, checks = 0;
    ent_t exp_q[$];
    logic [31:0] model_pc = RST_PC;
    bit dead = 0;
    logic [31:0] err_addr = 32'h0;
    bit rand_err = 0, rand_delay = 0;
    int rsp_delay = 0, pend = -1, acc_cnt = 0, del_cnt = 0;
    logic [31:0] paddr, acc_addrs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit mem_err(input logic [31:0] a);
        return (a == err_addr) || (rand_err && a[6:2] == 5'd9);
    endfunction

    // Sequential stream from the last redirect; the bus model decides which words fault.
    function automatic void refill();
        while (!dead && exp_q.size() < 4) begin
            exp_q.push_back('{inst: mem_err(model_pc) ? NOP : (model_pc ^ 32'h1),
                              pc: model_pc, fault: mem_err(model_pc)});
            model_pc += 32'd4;
        end
    endfunction

    function automatic void model_redirect(input logic [31:0] p);
        exp_q.delete();
        if (p[1:0] != 2'b00) begin
            exp_q.push_back('{inst: NOP, pc: p, fault: 1'b1});
            dead = 1;
        end else begin
            dead = 0;
            model_pc = p;
            refill();
        end
    endfunction

    initial forever begin
        @(posedge clk);
        refill();
    end

    // Memory: a request accepted at an edge is answered 'delay' cycles later.
    initial begin
        bit acc, rsp_now;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            acc = rst_n && mem_req_valid && mem_req_ready;
            a = mem_req_addr;
            rsp_now = mem_rsp_valid;
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = -1;
                mem_rsp_valid = 1'b0;
                continue;
            end
            if (rsp_now) mem_rsp_valid = 1'b0;
            if (acc) begin
                acc_cnt++;
                acc_addrs.push_back(a);
                check("req_addr_aligned", {62'd0, a[1:0]}, 64'd0);
                pend = rand_delay ? int'($urandom_range(0, 3)) : rsp_delay;
                paddr = a;
            end
            if (pend == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = paddr ^ 32'h1;
                mem_rsp_err = mem_err(paddr);
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
        end
    end

    // Monitor: pops the scoreboard on every decode handshake, checks request protocol.
    initial begin
        ent_t e;
        bit prev_valid = 0, prev_acc = 0, prev_halt = 0;
        logic [31:0] prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                continue;
            end
            if (inst_valid && inst_ready) begin
                del_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h while nothing expected", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
                    check("inst", {32'd0, inst}, {32'd0, e.inst});
                    check("inst_fault", {63'd0, inst_fault}, {63'd0, e.fault});
                end
            end
            if (mem_req_valid && !prev_valid) begin
                check("req_while_halt", {63'd0, prev_halt}, 64'd0);
                check("req_while_fault_idle", {63'd0, dead}, 64'd0);
            end
            if (mem_req_valid && prev_valid && !prev_acc)
                check("req_addr_stable", {32'd0, mem_req_addr}, {32'd0, prev_addr});
            if (prev_valid && !prev_acc)
                check("req_valid_held", {63'd0, mem_req_valid}, 64'd1);
            prev_valid = mem_req_valid;
            prev_acc = mem_req_ready;
            prev_addr = mem_req_addr;
            prev_halt = halt;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] p);
        redirect_pc = p;
        redirect_valid = 1'b1;
        @(posedge clk);
        model_redirect(p);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no request accepted within 40 cycles, required one", name);
        end
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_req_addr", {32'd0, mem_req_addr}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_inst_fault", {63'd0, inst_fault}, 64'd0);
        redirect_valid = 1'b0;
        halt = 1'b0;
        pend = -1;
        mem_rsp_valid = 1'b0;
        acc_addrs.delete();
        acc_cnt = 0;
        model_redirect(RST_PC);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("first_req_addr", {32'd0, mem_req_addr}, {32'd0, RST_PC});
    endtask

    initial begin
        int n, d;
        logic [31:0] a0, p;

        // Zero-latency streaming after reset.
        do_reset();
        tick(20);
        for (int k = 0; k < 4; k++)
            check("stream_addr", {32'd0, acc_addrs[k]}, {32'd0, RST_PC + 32'(4 * k)});

        // Decode stalled: the buffer fills with two entries and fetch stops.
        inst_ready = 1'b0;
        do_reset();
        tick(12);
        check("full_acc_cnt", 64'(acc_cnt), 64'd2);
        check("full_inst_valid", {63'd0, inst_valid}, 64'd1);
        check("full_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("full_head_pc", {32'd0, inst_pc}, {32'd0, RST_PC});
        inst_ready = 1'b1;
        tick(12);
        check("resume_addr", {32'd0, acc_addrs[2]}, {32'd0, RST_PC + 32'd8});

        // Redirect while a slow response is outstanding.
        rsp_delay = 3;
        wait_acc("t3_acc");
        d = del_cnt;
        pulse_redirect(32'h8000_0100);
        tick(20);
        check("t3_progress", {63'd0, del_cnt > d}, 64'd1);

        // Request held by a stalled bus, redirected mid-stall.
        rsp_delay = 0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 20 && !mem_req_valid; i++) tick(1);
        a0 = mem_req_addr;
        tick(1);
        check("t4_hold1", {32'd0, mem_req_addr}, {32'd0, a0});
        pulse_redirect(32'h8000_0200);
        tick(1);
        check("t4_hold3", {32'd0, mem_req_addr}, {32'd0, a0});
        tick(1);
        check("t4_hold4", {32'd0, mem_req_addr}, {32'd0, a0});
        mem_req_ready = 1'b1;
        wait_acc("t4_acc_old");
        check("t4_old_addr", {32'd0, acc_addrs[$]}, {32'd0, a0});
        wait_acc("t4_acc_new");
        check("t4_new_addr", {32'd0, acc_addrs[$]}, 64'h8000_0200);

        // Bus error at 8000_0008, then a misaligned redirect.
        err_addr = RST_PC + 32'd8;
        do_reset();
        tick(16);
        pulse_redirect(32'h8000_0102);
        tick(10);
        n = acc_cnt;
        tick(10);
        check("t5_no_req", 64'(acc_cnt), 64'(n));
        check("t5_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("t5_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("t5_fault_drained", 64'(exp_q.size()), 64'd0);
        err_addr = 32'h0;

        // Halt during WAIT, then asynchronous reset during WAIT.
        do_reset();
        rsp_delay = 3;
        wait_acc("t6_acc");
        halt = 1'b1;
        n = acc_cnt;
        d = del_cnt;
        tick(12);
        check("halt_no_req", 64'(acc_cnt), 64'(n));
        check("halt_delivered", 64'(del_cnt), 64'(d + 1));
        check("halt_req_valid", {63'd0, mem_req_valid}, 64'd0);
        halt = 1'b0;
        wait_acc("t6_resume");
        do_reset();

        // Randomized traffic.
        rand_delay = 1;
        rand_err = 1;
        do_reset();
        d = del_cnt;
        for (int i = 0; i < 3000; i++) begin
            mem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) halt = !halt;
            if ($urandom_range(0, 24) == 0) begin
                p = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
                if ($urandom_range(0, 5) == 0) p[1:0] = 2'($urandom_range(1, 3));
                pulse_redirect(p);
            end else begin
                tick(1);
            end
        end
        halt = 1'b0;
        inst_ready = 1'b1;
        mem_req_ready = 1'b1;
        tick(30);
        check("rand_progress", {63'd0, del_cnt > d + 100}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
